// File: rtl/simple_alu_pipe.sv
// Two-stage pipelined integer ALU for a simple execute lane: S1 captures the op,
// S2 computes and holds the result under a valid/ready handshake with flush.
`timescale 1ns/1ps

`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 8
`endif
`ifndef EXECUTION_FLAGS
`define EXECUTION_FLAGS 6
`endif
`ifndef NOP
`define NOP   8'h00
`endif
`ifndef ADD
`define ADD   8'h40
`endif
`ifndef ADDI
`define ADDI  8'h41
`endif
`ifndef ADDU
`define ADDU  8'h42
`endif
`ifndef ADDIU
`define ADDIU 8'h43
`endif
`ifndef SUB
`define SUB   8'h44
`endif
`ifndef SUBU
`define SUBU  8'h45
`endif
`ifndef MFHI
`define MFHI  8'h4a
`endif
`ifndef MTHI
`define MTHI  8'h4b
`endif
`ifndef MFLO
`define MFLO  8'h4c
`endif
`ifndef MTLO
`define MTLO  8'h4d
`endif
`ifndef AND
`define AND   8'h4e
`endif
`ifndef ANDI
`define ANDI  8'h4f
`endif
`ifndef OR
`define OR    8'h50
`endif
`ifndef ORI
`define ORI   8'h51
`endif
`ifndef XOR
`define XOR   8'h52
`endif
`ifndef XORI
`define XORI  8'h53
`endif
`ifndef NOR
`define NOR   8'h54
`endif
`ifndef SLL
`define SLL   8'h55
`endif
`ifndef SLLV
`define SLLV  8'h56
`endif
`ifndef SRL
`define SRL   8'h57
`endif
`ifndef SRLV
`define SRLV  8'h58
`endif
`ifndef SRA
`define SRA   8'h59
`endif
`ifndef SRAV
`define SRAV  8'h5a
`endif
`ifndef SLT
`define SLT   8'h5b
`endif
`ifndef SLTI
`define SLTI  8'h5c
`endif
`ifndef SLTU
`define SLTU  8'h5d
`endif
`ifndef SLTIU
`define SLTIU 8'h5e
`endif
`ifndef LUI
`define LUI   8'ha2
`endif

module simple_alu_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int IMM_WIDTH    = 16,
    parameter int OPCODE_WIDTH = `SIZE_OPCODE_I,
    parameter int TAG_WIDTH    = 7,
    parameter int FLAGS_WIDTH  = `EXECUTION_FLAGS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_WIDTH-1:0]   data1_i,
    input  logic [DATA_WIDTH-1:0]   data2_i,
    input  logic [IMM_WIDTH-1:0]    immd_i,
    input  logic [OPCODE_WIDTH-1:0] opcode_i,
    input  logic [TAG_WIDTH-1:0]    tag_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_WIDTH-1:0]   result_o,
    output logic [FLAGS_WIDTH-1:0]  flags_o,
    output logic [TAG_WIDTH-1:0]    tag_o
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int MSB = DATA_WIDTH - 1;

    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_d1, s1_d2, s1_sx, s1_zx;
    logic [OPCODE_WIDTH-1:0] s1_opcode;
    logic [TAG_WIDTH-1:0]    s1_tag;

    logic s2_load, accept;
    logic [DATA_WIDTH-1:0]  alu_result;
    logic [FLAGS_WIDTH-1:0] alu_flags;

    // S2 may take a new op whenever its current contents are absent or leaving.
    assign s2_load    = !out_valid_o || out_ready_i;
    assign in_ready_o = !reset && !flush_i && (!s1_valid || s2_load);
    assign accept     = in_valid_i && in_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, letting S2 read S1 in the same edge S1 reloads.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            s1_valid <= 1'b0;
        end else if (!s1_valid || s2_load) begin
            s1_valid <= accept;
        end
        if (accept) begin
            s1_d1     <= data1_i;
            s1_d2     <= data2_i;
            s1_sx     <= {{(DATA_WIDTH-IMM_WIDTH){immd_i[IMM_WIDTH-1]}}, immd_i};
            s1_zx     <= {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, immd_i};
            s1_opcode <= opcode_i;
            s1_tag    <= tag_i;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        logic exc, nop, illegal;
        alu_result = '0;
        alu_flags  = '0;
        exc        = 1'b0;
        nop        = 1'b0;
        illegal    = 1'b0;
        case (s1_opcode)
            `ADD: begin
                alu_result = s1_d1 + s1_d2;
                exc = (s1_d1[MSB] == s1_d2[MSB]) && (alu_result[MSB] != s1_d1[MSB]);
            end
            `ADDI: begin
                alu_result = s1_d1 + s1_sx;
                exc = (s1_d1[MSB] == s1_sx[MSB]) && (alu_result[MSB] != s1_d1[MSB]);
            end
            `SUB: begin
                alu_result = s1_d1 - s1_d2;
                exc = (s1_d1[MSB] != s1_d2[MSB]) && (alu_result[MSB] != s1_d1[MSB]);
            end
            `ADDU:  alu_result = s1_d1 + s1_d2;
            `ADDIU: alu_result = s1_d1 + s1_sx;
            `SUBU:  alu_result = s1_d1 - s1_d2;
            `AND:   alu_result = s1_d1 & s1_d2;
            `OR:    alu_result = s1_d1 | s1_d2;
            `XOR:   alu_result = s1_d1 ^ s1_d2;
            `NOR:   alu_result = ~(s1_d1 | s1_d2);
            `ANDI:  alu_result = s1_d1 & s1_zx;
            `ORI:   alu_result = s1_d1 | s1_zx;
            `XORI:  alu_result = s1_d1 ^ s1_zx;
            `SLL:   alu_result = s1_d1 << s1_zx[SHW-1:0];
            `SRL:   alu_result = s1_d1 >> s1_zx[SHW-1:0];
            `SRA:   alu_result = $signed(s1_d1) >>> s1_zx[SHW-1:0];
            `SLLV:  alu_result = s1_d2 << s1_d1[SHW-1:0];
            `SRLV:  alu_result = s1_d2 >> s1_d1[SHW-1:0];
            `SRAV:  alu_result = $signed(s1_d2) >>> s1_d1[SHW-1:0];
            `SLT:   alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(s1_d1) < $signed(s1_d2)};
            `SLTI:  alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(s1_d1) < $signed(s1_sx)};
            `SLTU:  alu_result = {{(DATA_WIDTH-1){1'b0}}, s1_d1 < s1_d2};
            `SLTIU: alu_result = {{(DATA_WIDTH-1){1'b0}}, s1_d1 < s1_zx};
            `LUI:   alu_result = {s1_zx[IMM_WIDTH-1:0], {(DATA_WIDTH-IMM_WIDTH){1'b0}}};
            `MFHI, `MTHI, `MFLO, `MTLO: alu_result = s1_d1;
            `NOP:   nop = 1'b1;
            default: illegal = 1'b1;
        endcase
        // Exceptions keep the computed result but suppress the register write.
        alu_flags[2] = 1'b1;
        if (exc || illegal) begin
            alu_flags[1] = 1'b1;
        end else if (!nop) begin
            alu_flags[4] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            out_valid_o <= 1'b0;
            result_o    <= '0;
            flags_o     <= '0;
            tag_o       <= '0;
        end else if (s2_load) begin
            out_valid_o <= s1_valid;
            if (s1_valid) begin
                result_o <= alu_result;
                flags_o  <= alu_flags;
                tag_o    <= s1_tag;
            end
        end
    end

endmodule
